// File: rtl/pcre_pkg.sv
// rtl/pcre_pkg.sv - shared types, constants and helpers for the PCRE result path
package pcre_pkg;

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

   localparam int PCRE_ID_NONE = 0;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/pcre_lsb_enc.sv
// rtl/pcre_lsb_enc.sv - lowest-set-bit encoder for one match-vector slice
module pcre_lsb_enc #(
   parameter int SLICE_W = 16,
   parameter int POS_W   = 4
) (
   input  logic [SLICE_W-1:0] bits,
   output logic [POS_W-1:0]   pos,
   output logic               nonzero
);

   // Scan downwards so the lowest set bit is the last one written.
   always_comb begin
      pos = '0;
      for (int i = SLICE_W - 1; i >= 0; i--) begin
         if (bits[i]) pos = POS_W'(i);
      end
      nonzero = |bits;
   end

endmodule

// File: rtl/pcre_id_serializer.sv
// rtl/pcre_id_serializer.sv - captures the PCRE match vector at EOP and streams every set rule ID
module pcre_id_serializer
   import pcre_pkg::*;
#(
   parameter int VEC_W   = 224,
   parameter int SLICE_W = 16,
   parameter int ID_W    = 10,
   parameter int ID_BASE = 0,
   parameter int FLOW_W  = 7,
   parameter int MAX_IDS = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [VEC_W-1:0]  vec_i,
   input  logic [FLOW_W-1:0] flow_i,
   input  logic              eop_i,
   output logic              ready_o,
   output logic              drop_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [ID_W-1:0]   id_o,
   output logic [FLOW_W-1:0] flow_o,
   output logic              last_o,
   output logic              trunc_o
);

   localparam int NUM_SLICES = VEC_W / SLICE_W;
   localparam int IDX_W      = (clog2(NUM_SLICES) < 1) ? 1 : clog2(NUM_SLICES);
   localparam int POS_W      = (clog2(SLICE_W) < 1) ? 1 : clog2(SLICE_W);
   localparam int CNT_W      = clog2(MAX_IDS + 1);

   state_t              state;
   logic [VEC_W-1:0]    work;
   logic [FLOW_W-1:0]   flow_r;
   logic [IDX_W-1:0]    idx;
   logic [CNT_W-1:0]    cnt;

   logic [SLICE_W-1:0]  slice;
   logic [POS_W-1:0]    pos;
   logic                slice_hit;
   int                  bit_pos;
   logic [VEC_W-1:0]    work_clr;
   logic                beat_last;
   logic [ID_W-1:0]     beat_id;
   logic                out_free;

   assign slice = work[int'(idx) * SLICE_W +: SLICE_W];

   pcre_lsb_enc #(
      .SLICE_W (SLICE_W),
      .POS_W   (POS_W)
   ) u_lsb_enc (
      .bits    (slice),
      .pos     (pos),
      .nonzero (slice_hit)
   );

   // IDs are 1-based so that 0 can mean "no match".
   assign bit_pos   = int'(idx) * SLICE_W + int'(pos);
   assign work_clr  = work & ~(VEC_W'(1) << bit_pos);
   assign beat_last = (work_clr == '0) || ((cnt + 1'b1) == CNT_W'(MAX_IDS));
   assign beat_id   = ID_W'(ID_BASE) + ID_W'(bit_pos) + ID_W'(1);
   assign out_free  = !valid_o || ready_i;
   assign ready_o   = (state == IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         work    <= '0;
         flow_r  <= '0;
         idx     <= '0;
         cnt     <= '0;
         valid_o <= 1'b0;
         id_o    <= '0;
         flow_o  <= '0;
         last_o  <= 1'b0;
         trunc_o <= 1'b0;
         drop_o  <= 1'b0;
      end else begin
         drop_o <= eop_i && (state != IDLE);
         if (valid_o && ready_i) valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (eop_i) begin
                  work   <= vec_i;
                  flow_r <= flow_i;
                  idx    <= '0;
                  cnt    <= '0;
                  state  <= SCAN;
               end
            end
            SCAN: begin
               if (out_free) begin
                  if (work == '0 && cnt == '0) begin
                     valid_o <= 1'b1;
                     id_o    <= ID_W'(PCRE_ID_NONE);
                     flow_o  <= flow_r;
                     last_o  <= 1'b1;
                     trunc_o <= 1'b0;
                     state   <= DRAIN;
                  end else if (slice_hit) begin
                     valid_o <= 1'b1;
                     id_o    <= beat_id;
                     flow_o  <= flow_r;
                     last_o  <= beat_last;
                     trunc_o <= beat_last && (work_clr != '0);
                     work    <= work_clr;
                     cnt     <= cnt + 1'b1;
                     if (beat_last) state <= DRAIN;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (valid_o && ready_i) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pcre_id_serializer.sv
// tb/tb_pcre_id_serializer.sv - scoreboard bench for pcre_id_serializer
module tb_pcre_id_serializer;

   typedef struct packed {
      logic [9:0] id;
      logic [6:0] flow;
      logic       last;
      logic       trunc;
   } beat_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [223:0] vec_i;
   logic [6:0]   flow_i;
   logic         eop_i, eop2;
   logic         ready_i;

   logic         ready_o, drop_o, valid_o, last_o, trunc_o;
   logic [9:0]   id_o;
   logic [6:0]   flow_o;
   logic         ready2, drop2, valid2, last2, trunc2;
   logic [9:0]   id2;
   logic [6:0]   flow2;

   int checks = 0;
   int errors = 0;
   beat_t q[$];
   beat_t q2[$];

   always #5 clk = ~clk;

   pcre_id_serializer u_dut (
      .clk (clk), .rst (rst), .vec_i (vec_i), .flow_i (flow_i), .eop_i (eop_i),
      .ready_o (ready_o), .drop_o (drop_o), .valid_o (valid_o), .ready_i (ready_i),
      .id_o (id_o), .flow_o (flow_o), .last_o (last_o), .trunc_o (trunc_o)
   );

   pcre_id_serializer #(.MAX_IDS(2)) u_dut2 (
      .clk (clk), .rst (rst), .vec_i (vec_i), .flow_i (flow_i), .eop_i (eop2),
      .ready_o (ready2), .drop_o (drop2), .valid_o (valid2), .ready_i (ready_i),
      .id_o (id2), .flow_o (flow2), .last_o (last2), .trunc_o (trunc2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cmp_beat(input string name, input beat_t act, input beat_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got id=%0d flow=%0d last=%0b trunc=%0b expected id=%0d flow=%0d last=%0b trunc=%0b",
                  name, act.id, act.flow, act.last, act.trunc, exp.id, exp.flow, exp.last, exp.trunc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && valid_o && ready_i) begin
         if (q.size() == 0) chk("dut_unexpected_beat", 32'(id_o), 32'hFFFF);
         else cmp_beat("dut_beat", {id_o, flow_o, last_o, trunc_o}, q.pop_front());
      end
      if (!rst && valid2 && ready_i) begin
         if (q2.size() == 0) chk("dut2_unexpected_beat", 32'(id2), 32'hFFFF);
         else cmp_beat("dut2_beat", {id2, flow2, last2, trunc2}, q2.pop_front());
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle(input string name, input int bound);
      int k = 0;
      while ((q.size() != 0 || q2.size() != 0 || !ready_o || !ready2) && k < bound) begin
         step();
         k++;
      end
      chk(name, 32'(k < bound), 32'd1);
   endtask

   task automatic capture(input logic [223:0] v, input logic [6:0] f);
      vec_i  = v;
      flow_i = f;
      eop_i  = 1'b1;
      step();
      eop_i  = 1'b0;
   endtask

   initial begin
      logic [223:0] v;
      rst = 1'b1; eop_i = 1'b0; eop2 = 1'b0; ready_i = 1'b1;
      vec_i = '0; flow_i = '0;
      step(3);
      rst = 1'b0;

      // reset state
      chk("rst_valid", 32'(valid_o), 0);
      chk("rst_ready", 32'(ready_o), 1);
      chk("rst_drop", 32'(drop_o), 0);
      chk("rst_id", 32'(id_o), 0);
      chk("rst_flow_last_trunc", {flow_o, last_o, trunc_o}, 0);

      // single match at bit 5
      v = '0; v[5] = 1'b1;
      q.push_back('{10'd6, 7'd3, 1'b1, 1'b0});
      capture(v, 7'd3);
      chk("bit5_not_early", 32'(valid_o), 0);
      step();
      chk("bit5_lat_valid", 32'(valid_o), 1);
      chk("bit5_lat_id", 32'(id_o), 6);
      wait_idle("bit5_done", 50);

      // spread matches across slices
      v = '0; v[0] = 1'b1; v[17] = 1'b1; v[223] = 1'b1;
      q.push_back('{10'd1, 7'd5, 1'b0, 1'b0});
      q.push_back('{10'd18, 7'd5, 1'b0, 1'b0});
      q.push_back('{10'd224, 7'd5, 1'b1, 1'b0});
      capture(v, 7'd5);
      step();
      chk("spread_first_id", 32'(id_o), 1);
      step();
      chk("spread_gap_valid", 32'(valid_o), 0);
      step();
      chk("spread_second_valid", 32'(valid_o), 1);
      chk("spread_second_id", 32'(id_o), 18);
      wait_idle("spread_done", 50);

      // empty vector gives the null beat
      q.push_back('{10'd0, 7'd9, 1'b1, 1'b0});
      capture('0, 7'd9);
      step();
      chk("null_lat_valid", 32'(valid_o), 1);
      chk("null_last", 32'(last_o), 1);
      wait_idle("null_done", 50);

      // truncation with MAX_IDS=2
      v = '0; v[1] = 1'b1; v[2] = 1'b1; v[3] = 1'b1;
      q2.push_back('{10'd2, 7'd2, 1'b0, 1'b0});
      q2.push_back('{10'd3, 7'd2, 1'b1, 1'b1});
      vec_i = v; flow_i = 7'd2; eop2 = 1'b1;
      step();
      eop2 = 1'b0;
      wait_idle("trunc_done", 50);

      // backpressure holds the first beat stable
      v = '0; v[0] = 1'b1; v[1] = 1'b1;
      ready_i = 1'b0;
      q.push_back('{10'd1, 7'd4, 1'b0, 1'b0});
      q.push_back('{10'd2, 7'd4, 1'b1, 1'b0});
      capture(v, 7'd4);
      step();
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", 32'(valid_o), 1);
         chk("hold_id", 32'(id_o), 1);
         step();
      end
      ready_i = 1'b1;
      wait_idle("hold_done", 50);

      // eop while scanning is dropped
      v = '0; v[0] = 1'b1; v[223] = 1'b1;
      q.push_back('{10'd1, 7'd6, 1'b0, 1'b0});
      q.push_back('{10'd224, 7'd6, 1'b1, 1'b0});
      capture(v, 7'd6);
      v = '0; v[7] = 1'b1;
      capture(v, 7'd1);
      chk("drop_pulse", 32'(drop_o), 1);
      step();
      chk("drop_one_cycle", 32'(drop_o), 0);
      wait_idle("drop_done", 50);

      // back-to-back capture right after the last beat
      v = '0; v[0] = 1'b1;
      q.push_back('{10'd1, 7'd1, 1'b1, 1'b0});
      capture(v, 7'd1);
      begin
         int k = 0;
         while (k < 20) begin
            @(negedge clk);
            if (valid_o && ready_i && last_o) break;
            k++;
         end
         chk("b2b_last_seen", 32'(k < 20), 1);
      end
      @(posedge clk); #1;
      chk("b2b_ready", 32'(ready_o), 1);
      v = '0; v[2] = 1'b1;
      q.push_back('{10'd3, 7'd2, 1'b1, 1'b0});
      capture(v, 7'd2);
      chk("b2b_no_drop", 32'(drop_o), 0);
      wait_idle("b2b_done", 50);

      // reset mid-stream discards the packet
      v = '0; v[0] = 1'b1; v[1] = 1'b1; v[2] = 1'b1;
      ready_i = 1'b0;
      capture(v, 7'd8);
      step(3);
      chk("pre_rst_valid", 32'(valid_o), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_valid", 32'(valid_o), 0);
      chk("mid_rst_ready", 32'(ready_o), 1);
      ready_i = 1'b1;
      step(4);
      chk("mid_rst_quiet", 32'(valid_o), 0);

      // reset wins over a simultaneous eop
      v = '0; v[0] = 1'b1;
      vec_i = v; rst = 1'b1; eop_i = 1'b1;
      step();
      rst = 1'b0; eop_i = 1'b0;
      step(3);
      chk("rst_eop_valid", 32'(valid_o), 0);
      chk("rst_eop_ready", 32'(ready_o), 1);

      chk("q_empty", 32'(q.size()), 0);
      chk("q2_empty", 32'(q2.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
